// File: rtl/uvmt_cv32e40x_sl_obi_resp_pkg.sv
// Shared types and constants for the support-logic OBI responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uvmt_cv32e40x_sl_obi_resp_pkg;

    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = 4;

    // Width of the per-entry countdown; the responder's DELAY_W must not exceed it.
    localparam int RESP_CNT_W = 8;

    typedef logic [RESP_CNT_W-1:0] resp_cnt_t;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
        resp_cnt_t             count;
    } resp_entry_t;

endpackage

// File: rtl/uvmt_cv32e40x_sl_obi_resp_queue.sv
// In-order response queue: DEPTH-entry circular FIFO, each entry counts down its own latency.
// Latency: an entry pushed with count d is head-ready d cycles after push at the earliest.
// Backpressure: none internally; the caller must not push when full (count == DEPTH).
module uvmt_cv32e40x_sl_obi_resp_queue
    import uvmt_cv32e40x_sl_obi_resp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  resp_entry_t                push_entry,
    output logic                       head_ready,
    output resp_entry_t                head_entry,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    resp_entry_t      entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // The head responds once its countdown has expired; younger expired entries wait their turn.
    always_comb begin
        head_entry = entries[rd_ptr];
        head_ready = valid[rd_ptr] && (entries[rd_ptr].count == '0);
    end

    // Countdown, push, pop and occupancy; the head pops on the same edge it is presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && (entries[i].count != '0)) begin
                    entries[i].count <= entries[i].count - 1'b1;
                end
            end
            if (head_ready) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            // The write slot is never the live head: pushes are refused while full.
            if (push) begin
                entries[wr_ptr] <= push_entry;
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            case ({push, head_ready})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uvmt_cv32e40x_sl_obi_responder.sv
// OBI responder backed by a word memory model, with grant stalling and per-request latency.
// Latency: response in cycle T+1+d after an accept ending cycle T, strictly in order.
// Backpressure: gnt_o withheld on stall_i or when DEPTH transactions are outstanding.
// Optional: UVMT_CV32E40X_SL_OBI_RESP_ERR_EN flags out-of-range accesses with err_o and drops their writes.
module uvmt_cv32e40x_sl_obi_responder
    import uvmt_cv32e40x_sl_obi_resp_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int MEM_WORDS = 256,
    parameter int DELAY_W   = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    output logic                       gnt_o,
    input  logic [31:0]                addr_i,
    input  logic                       we_i,
    input  logic [OBI_BE_W-1:0]        be_i,
    input  logic [OBI_DATA_W-1:0]      wdata_i,
    input  logic                       stall_i,
    input  logic [DELAY_W-1:0]         rvalid_delay_i,
    output logic                       rvalid_o,
    output logic [OBI_DATA_W-1:0]      rdata_o,
    output logic                       err_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int OUT_W = $clog2(DEPTH + 1);

    logic [OBI_DATA_W-1:0] mem [MEM_WORDS];
    logic [IDX_W-1:0]      idx;
    logic [OUT_W-1:0]      outstanding;
    logic                  accept;
    logic                  addr_err;
    logic                  mem_we;
    logic                  head_ready;
    resp_entry_t           push_entry;
    resp_entry_t           head_entry;
    logic                  unused_addr;

    assign idx         = addr_i[2 +: IDX_W];
    assign unused_addr = ^{addr_i[1:0], addr_i[31:2+IDX_W]};

`ifdef UVMT_CV32E40X_SL_OBI_RESP_ERR_EN
    assign addr_err = (addr_i[31:2] >= 30'(MEM_WORDS));
`else
    assign addr_err = 1'b0;
`endif

    // No grant at full, even when the head pops this cycle; none at all while in reset.
    assign gnt_o  = req_i && !stall_i && (outstanding != OUT_W'(DEPTH)) && !rst_i;
    assign accept = req_i && gnt_o;
    assign mem_we = accept && we_i && !addr_err;

    // Response payload captured at accept: writes and errored accesses return zero data.
    always_comb begin
        push_entry       = '0;
        push_entry.err   = addr_err;
        push_entry.count = resp_cnt_t'(rvalid_delay_i);
        if (!we_i && !addr_err) begin
            push_entry.rdata = mem[idx];
        end
    end

    // Memory model: cleared by reset, byte-enabled write at the accept edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < MEM_WORDS; w++) begin
                mem[w] <= '0;
            end
        end else if (mem_we) begin
            for (int k = 0; k < OBI_BE_W; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    uvmt_cv32e40x_sl_obi_resp_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (accept),
        .push_entry (push_entry),
        .head_ready (head_ready),
        .head_entry (head_entry),
        .count      (outstanding)
    );

    // Response outputs are zero outside the single-cycle valid pulse.
    always_comb begin
        rvalid_o = head_ready && !rst_i;
        rdata_o  = rvalid_o ? head_entry.rdata : '0;
        err_o    = rvalid_o ? head_entry.err : 1'b0;
    end

    assign outstanding_o = outstanding;

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_obi_responder.sv
// Bench for the support-logic OBI responder: scoreboard of expected responses and cycles.
// Latency: model predicts max(accept_cycle + d, previous_response + 1).
// Backpressure: driver waits (bounded) for gnt_o before committing an accept.
module tb_uvmt_cv32e40x_sl_obi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall;
    logic [2:0]  dly;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  outstanding;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_exp = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    logic [31:0] mem_model [256];

    uvmt_cv32e40x_sl_obi_responder #(
        .DEPTH     (2),
        .MEM_WORDS (256),
        .DELAY_W   (3)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .gnt_o          (gnt),
        .addr_i         (addr),
        .we_i           (we),
        .be_i           (be),
        .wdata_i        (wdata),
        .stall_i        (stall),
        .rvalid_delay_i (dly),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .err_o          (err),
        .outstanding_o  (outstanding)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: occupancy, response data, error and response cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_checks++;
            if ({30'b0, outstanding} !== 32'(sb.size())) begin
                n_fail++;
                $display("FAIL outstanding cyc=%0d got=%0d want=%0d", cyc, outstanding, sb.size());
            end
            if (rvalid === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid cyc=%0d rdata=%h", cyc, rdata);
                end else begin
                    e = sb.pop_front();
                    if (rdata !== e.rdata || err !== e.err || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL response got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                                 rdata, err, cyc, e.rdata, e.err, e.cyc);
                    end
                end
            end else begin
                n_checks++;
                if (rdata !== 32'h0 || err !== 1'b0 || rvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs cyc=%0d rvalid=%b rdata=%h err=%b", cyc, rvalid, rdata, err);
                end
            end
        end
    end

    // Drive one request, wait (bounded) for the grant, then model the accepted transaction.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] wd, input int d, output int acc_cyc);
        logic        granted;
        logic        in_rng;
        logic        err_exp;
        logic [31:0] rd_exp;
        int          ec;
        req = 1'b1; addr = a; we = w; be = b; wdata = wd; dly = 3'(d);
        granted = 1'b0;
        for (int i = 0; i < 100 && !granted; i++) begin
            @(negedge clk);
            if (gnt === 1'b1) granted = 1'b1;
        end
        n_checks++;
        if (!granted) begin
            n_fail++;
            $display("FAIL grant_timeout addr=%h got gnt=%b want 1", a, gnt);
            req = 1'b0;
            acc_cyc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_rng  = (a[31:2] < 30'd256);
`ifdef UVMT_CV32E40X_SL_OBI_RESP_ERR_EN
        err_exp = !in_rng;
`else
        err_exp = 1'b0;
`endif
        rd_exp = 32'h0;
        if (w) begin
            if (!err_exp) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) mem_model[a[9:2]][8*k +: 8] = wd[8*k +: 8];
                end
            end
        end else if (!err_exp) begin
            rd_exp = mem_model[a[9:2]];
        end
        ec = cyc + d;
        if (ec <= last_exp) ec = last_exp + 1;
        last_exp = ec;
        sb.push_back('{rdata: rd_exp, err: err_exp, cyc: ec});
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0; addr = 32'h0; dly = 3'd0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout got pending=%0d want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; idle(); req = 1'b1;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs got gnt=%b rvalid=%b rdata=%h err=%b want all 0",
                         gnt, rvalid, rdata, err);
            end
        end
        n_checks++;
        if (outstanding !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outstanding got=%0d want=0", outstanding);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; idle();
        last_exp = cyc;
    endtask

    task automatic test_write_read();
        int k;
        do_req(32'h100, 1'b1, 4'b0101, 32'hDEADBEEF, 0, k);
        do_req(32'h100, 1'b0, 4'b0000, 32'h0, 0, k);
        idle();
        wait_drain();
        n_checks++;
        if (mem_model[64] !== 32'h00AD00EF) begin
            n_fail++;
            $display("FAIL be_merge_model got=%h want=00ad00ef", mem_model[64]);
        end
    endtask

    task automatic test_order();
        int ka, kb;
        do_req(32'h300, 1'b1, 4'hF, 32'hA5A5_0001, 0, ka);
        do_req(32'h304, 1'b1, 4'hF, 32'h5A5A_0002, 0, ka);
        idle();
        wait_drain();
        do_req(32'h300, 1'b0, 4'h0, 32'h0, 5, ka);
        do_req(32'h304, 1'b0, 4'h0, 32'h0, 0, kb);
        idle();
        n_checks++;
        if (kb != ka + 1) begin
            n_fail++;
            $display("FAIL order_consecutive_accept got=%0d want=%0d", kb, ka + 1);
        end
        wait_drain();
    endtask

    task automatic test_full();
        int k1, k2, k3;
        do_req(32'h200, 1'b0, 4'h0, 32'h0, 3, k1);
        do_req(32'h204, 1'b0, 4'h0, 32'h0, 3, k2);
        addr = 32'h208;
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b0 || outstanding !== 2'd2) begin
            n_fail++;
            $display("FAIL full_grant got gnt=%b outstanding=%0d want gnt=0 outstanding=2", gnt, outstanding);
        end
        do_req(32'h208, 1'b0, 4'h0, 32'h0, 3, k3);
        idle();
        n_checks++;
        if (k3 != k1 + 5) begin
            n_fail++;
            $display("FAIL full_regrant got accept=%0d want=%0d", k3, k1 + 5);
        end
        wait_drain();
    endtask

    task automatic test_stall();
        int k;
        stall = 1'b1; req = 1'b1; addr = 32'h10; we = 1'b0; dly = 3'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_gnt cycle=%0d got=%b want=0", i, gnt);
            end
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release got gnt=%b want=1", gnt);
        end
        req = 1'b0;
        @(posedge clk);
        #1;
        do_req(32'h10, 1'b0, 4'h0, 32'h0, 1, k);
        idle();
        wait_drain();
    endtask

    task automatic test_random();
        int          k;
        logic [31:0] a;
        for (int i = 0; i < 10; i++) begin
            a = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
            do_req(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                   int'($urandom_range(0, 7)), k);
        end
        idle();
        wait_drain();
    endtask

    task automatic test_oob();
        int k;
        do_req(32'h000, 1'b1, 4'hF, 32'h1234_5678, 0, k);
        do_req(32'h400, 1'b0, 4'h0, 32'h0, 1, k);
        do_req(32'h404, 1'b1, 4'hF, 32'hFFFF_0000, 0, k);
        do_req(32'h004, 1'b0, 4'h0, 32'h0, 2, k);
        idle();
        wait_drain();
    endtask

    task automatic test_reset_pending();
        int k;
        do_req(32'h300, 1'b0, 4'h0, 32'h0, 7, k);
        do_req(32'h304, 1'b0, 4'h0, 32'h0, 7, k);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (outstanding !== 2'd0 || rvalid !== 1'b0 || gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending got outstanding=%0d rvalid=%b gnt=%b want 0 0 0",
                     outstanding, rvalid, gnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; idle();
        last_exp = cyc;
        repeat (12) @(posedge clk);
        #1;
        do_req(32'h100, 1'b0, 4'h0, 32'h0, 0, k);
        do_req(32'h300, 1'b0, 4'h0, 32'h0, 2, k);
        idle();
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_order();
        test_full();
        test_stall();
        test_random();
        test_oob();
        test_reset_pending();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
